// File: rtl/sort_seq.sv
// ---------------------------------------------------------------------------
// sort_seq
//   Registered thermometer sorter for oversampled bit vectors. All ones of the
//   N = SAMPLES*OSF bit input are packed toward bit 0 by odd-even transposition,
//   one pass per clock, stopping as soon as the vector is sorted.
//
//   Optional feature: define SORT_COUNT_EN to add the ones_count output
//   (popcount of the result, registered alongside data_out).
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    data_in valid (ignored outside IDLE)
//   in_ready    high only in IDLE
//   data_in     raw oversampled vector [N-1:0]
//   out_valid   sorted result available (DONE)
//   out_ready   consumer accepts result
//   data_out    sorted thermometer vector, ones at LSBs (held until next result)
//   pass_count  number of passes applied to the current result
//   ones_count  number of ones in data_out (SORT_COUNT_EN only)
// ---------------------------------------------------------------------------
module sort_seq #(
    parameter  int SAMPLES = 2,
    parameter  int OSF     = 8,
    localparam int N       = SAMPLES * OSF,
    localparam int CW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic [CW-1:0] pass_count
`ifdef SORT_COUNT_EN
    ,
    output logic [CW-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  q, q_nxt, q_pass;
    logic          ph, ph_nxt;
    logic [CW-1:0] pc, pc_nxt;
    logic [N-1:0]  dout_nxt;
    logic [CW-1:0] pcnt_nxt;
    logic          sorted;

    // No 0 sits directly below a 1 anywhere in the vector.
    assign sorted = ~|(~q[N-2:0] & q[N-1:1]);

    // One transposition pass. Pairs of a given phase never overlap, so every
    // pair reads the unmodified q and the results can be merged in place.
    always_comb begin
        q_pass = q;
        for (int unsigned k = 0; k < N - 1; k++) begin
            if ((k[0] == ph) && !q[k] && q[k+1]) begin
                q_pass[k]   = 1'b1;
                q_pass[k+1] = 1'b0;
            end
        end
    end

`ifdef SORT_COUNT_EN
    logic [CW-1:0] popcnt, ones_nxt;

    always_comb begin
        popcnt = '0;
        for (int unsigned k = 0; k < N; k++) begin
            popcnt = popcnt + CW'(q[k]);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        ph_nxt    = ph;
        pc_nxt    = pc;
        dout_nxt  = data_out;
        pcnt_nxt  = pass_count;
`ifdef SORT_COUNT_EN
        ones_nxt  = ones_count;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    q_nxt     = data_in;
                    ph_nxt    = 1'b0;
                    pc_nxt    = '0;
                    state_nxt = SORT;
                end
            end
            SORT: begin
                if (sorted) begin
                    dout_nxt  = q;
                    pcnt_nxt  = pc;
`ifdef SORT_COUNT_EN
                    ones_nxt  = popcnt;
`endif
                    state_nxt = DONE;
                end else begin
                    q_nxt  = q_pass;
                    ph_nxt = ~ph;
                    pc_nxt = pc + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            ph         <= 1'b0;
            pc         <= '0;
            data_out   <= '0;
            pass_count <= '0;
`ifdef SORT_COUNT_EN
            ones_count <= '0;
`endif
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            ph         <= ph_nxt;
            pc         <= pc_nxt;
            data_out   <= dout_nxt;
            pass_count <= pcnt_nxt;
`ifdef SORT_COUNT_EN
            ones_count <= ones_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sort_seq.sv
// ---------------------------------------------------------------------------
// tb_sort_seq
//   Scoreboard bench for sort_seq: the driver pushes the expected result of
//   each accepted vector, a negedge monitor pops and compares it when the DUT
//   presents out_valid, and keeps comparing while the result is held.
// ---------------------------------------------------------------------------
module tb_sort_seq;

    localparam int SAMPLES = 2;
    localparam int OSF     = 8;
    localparam int N       = SAMPLES * OSF;
    localparam int CW      = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  data_out;
    logic [CW-1:0] pass_count;
`ifdef SORT_COUNT_EN
    logic [CW-1:0] ones_count;
`endif

    sort_seq #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .pass_count (pass_count)
`ifdef SORT_COUNT_EN
        ,
        .ones_count (ones_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           pc;
        int           ones;
        longint       acc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    logic   rst_edge = 1'b0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the result is simply popcount ones at the bottom; the pass
    // count is found by running odd/even swap rounds on a copy until equal.
    function automatic void model(input logic [N-1:0] v, output logic [N-1:0] res,
                                  output int passes, output int ones);
        logic [N-1:0] cur, nxt;
        int ph;
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(v[i]);
        res = '0;
        for (int i = 0; i < ones; i++) res[i] = 1'b1;
        cur = v;
        ph = 0;
        passes = 0;
        while (cur != res && passes <= N) begin
            nxt = cur;
            for (int k = ph; k + 1 < N; k += 2) begin
                if (cur[k+1] && !cur[k]) begin
                    nxt[k]   = 1'b1;
                    nxt[k+1] = 1'b0;
                end
            end
            cur = nxt;
            ph = 1 - ph;
            passes++;
        end
    endfunction

    // Monitor
    exp_t cur_e;
    bit   active = 0;

    always @(negedge clk) begin
        if (rst || rst_edge) begin
            active = 0;
        end else if (out_valid) begin
            if (!active) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    cur_e = sb.pop_front();
                    active = 1;
                    chk("latency", cyc - cur_e.acc + 1, cur_e.pc + 2);
                end
            end
            if (active) begin
                chk("data_out", data_out, cur_e.data);
                chk("pass_count", pass_count, cur_e.pc);
                chk("in_ready_in_done", in_ready, 0);
`ifdef SORT_COUNT_EN
                chk("ones_count", ones_count, cur_e.ones);
`endif
            end
        end else begin
            active = 0;
        end
    end

    task automatic run_vec(input logic [N-1:0] v, input int hold, input bit pulse);
        exp_t e;
        int   w;
        model(v, e.data, e.pc, e.ones);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        data_in  = v;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = N'($urandom);
        w = 0;
        while (!out_valid && w < N + 8) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            sb.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = 1'b1;
                data_in  = N'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("held_data_out", data_out, e.data);
        chk("held_pass_count", pass_count, e.pc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_pass_count", pass_count, 0);
`ifdef SORT_COUNT_EN
        chk("rst_ones_count", ones_count, 0);
`endif
        rst = 1'b0;

        // Directed vectors
        run_vec(16'hA5A5, 0, 0);
        run_vec(16'h000F, 0, 0);
        run_vec(16'h0000, 0, 0);
        run_vec(16'hFFFF, 0, 0);
        run_vec(16'h8000, 0, 0);
        // Backpressure with ignored input pulses
        run_vec(16'h1234, 5, 1);

        // Reset during SORT
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'hF000;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_pass_count", pass_count, 0);
`ifdef SORT_COUNT_EN
        chk("midrst_ones_count", ones_count, 0);
`endif
        sb.delete();
        run_vec(16'h0003, 0, 0);

        // Randomized vectors
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if (($urandom % 8) == 0) v = N'(1) << ($urandom % N);
            run_vec(v, int'($urandom % 4), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_seq.md
# sort_seq

Clocked, parametrised thermometer sorter for oversampled bit vectors. It packs all ones of an N = SAMPLES*OSF bit input toward bit 0 using odd-even transposition, one pass per clock, and stops early once the vector is sorted. It has valid/ready handshakes on both sides and sits between the oversampling capture stage and the downstream count/decision logic. It is the registered successor to the latch-based precharge/sort array.

## Interface
- SAMPLES, default 2: samples per frame.
- OSF, default 8: oversampling factor.
- N (localparam) = SAMPLES*OSF; CW (localparam) = $clog2(N+1).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block accepts a new vector (high only in IDLE).
- data_in  in  N  raw oversampled vector.
- out_valid  out  1  sorted result available.
- out_ready  in  1  consumer accepts result.
- data_out  out  N  sorted thermometer vector, ones at LSBs.
- pass_count  out  CW  number of sort passes applied to the current result.
- ones_count  out  CW  binary number of ones (only with SORT_COUNT_EN).

## Operation
- Working register q[N-1:0]; phase bit ph; pass counter pc[CW-1:0].
- sorted = ~|(~q[N-2:0] & q[N-1:1]), i.e. no 0 sits below a 1.
- Pass rule for pair (k, k+1): if q[k]==0 and q[k+1]==1, then q[k] is set to 1 and q[k+1] is cleared to 0; otherwise the pair is unchanged.
- Even phase (ph=0): pairs (0,1),(2,3),… Odd phase (ph=1): pairs (1,2),(3,4),… The top or bottom bit without a partner is unchanged.
- FSM states:
  - IDLE: in_ready=1. On in_valid: q<=data_in, ph<=0, pc<=0, go to SORT.
  - SORT: if sorted, then data_out<=q, pass_count<=pc, go to DONE. Otherwise apply one pass, toggle ph, pc<=pc+1, stay in SORT.
  - DONE: out_valid=1. data_out and pass_count are held. On out_ready, go to IDLE.
- pc never exceeds N; odd-even transposition on N bits guarantees sorting within N passes.
- data_out and pass_count change only on the SORT→DONE transition. They hold their last value through IDLE and SORT.
- in_valid outside IDLE is ignored; there is no buffering.
- Edge vectors: all-zero and all-ones inputs are already sorted and need 0 passes.

## Timing
- Input handshake at edge T: the first SORT evaluation happens in cycle T+1.
- With P passes needed (0..N), out_valid rises at T+2+P.
- Best case latency is 2 cycles; worst case is N+2.
- In DONE, with out_ready high at edge D, the block is in IDLE at D+1 with in_ready=1. The next accept is no earlier than D+1, so peak throughput is one vector per P+3 cycles.
- out_valid stays high with data_out stable for as long as out_ready is low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, data_out=0, pass_count=0, ones_count=0, q=0, ph=0, pc=0.
- Reset asserted in SORT or DONE: the state returns to IDLE at the next edge and the pending result is discarded (out_valid=0, data_out=0). rst has priority over all handshakes.

## Configuration
- SORT_COUNT_EN defined:
  - ones_count port exists.
  - It is registered on the SORT→DONE transition as the popcount of q, which equals the thermometer length of data_out.
  - It is held like data_out and reset to 0.
- SORT_COUNT_EN undefined: the ones_count port and its logic are absent. All other behaviour is identical.

## Test plan
Defaults (N=16, CW=5), SORT_COUNT_EN defined unless noted.
- data_in=16'hA5A5 → data_out=16'h00FF, ones_count=8, pass_count≤16, out_valid by T+18.
- data_in=16'h000F (already sorted) → out_valid at exactly T+2, data_out=16'h000F, pass_count=0. Repeat with 16'h0000 and 16'hFFFF: same timing, output equal to input.
- data_in=16'h8000 → data_out=16'h0001, pass_count=15, out_valid at T+17, ones_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1, data_out/pass_count stable, in_ready=0, and a pulsed in_valid is ignored. Release → IDLE next cycle.
- Assert rst for 1 cycle during SORT of 16'hF000 → next cycle state=IDLE, in_ready=1, out_valid=0, data_out=0. A following 16'h0003 sorts correctly with pass_count=0.
- Build without SORT_COUNT_EN and rerun the first scenario → identical data_out, pass_count and timing.
